// File: rtl/cdb_arbiter_pkg.sv
// Shared back-end types for the common-data-bus arbiter.
// Holds the ROB/physical-register address and data types and the CDB
// result packet. The request array and the broadcast register both use
// this packet.
package cdb_arbiter_pkg;

  localparam int unsigned ROB_ADDR_W    = 5;
  localparam int unsigned PHY_RF_ADDR_W = 6;
  localparam int unsigned PHY_RF_DATA_W = 32;

  typedef logic [ROB_ADDR_W-1:0]    rob_addr_t;
  typedef logic [PHY_RF_ADDR_W-1:0] phy_rf_addr_t;
  typedef logic [PHY_RF_DATA_W-1:0] phy_rf_data_t;

  typedef struct packed {
    rob_addr_t    rob_addr;
    phy_rf_addr_t phy_addr;
    phy_rf_data_t data;
    logic         wr_rf;
  } cdb_pkt_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Result-request bus between the functional units and the CDB arbiter.
// Signals:
//   req_valid    : result pending, one bit per unit
//   req_ready    : one-hot grant back to the units
//   req_rob_addr : ROB entry of each pending result
//   req_phy_addr : destination physical register
//   req_data     : result value
//   req_wr_rf    : result writes the register file
// Modports:
//   master : functional-unit side (drives valid and payload)
//   slave  : arbiter side (drives ready)
interface cdb_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  import cdb_arbiter_pkg::*;

  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] req_ready;
  rob_addr_t        req_rob_addr [N_REQ];
  phy_rf_addr_t     req_phy_addr [N_REQ];
  phy_rf_data_t     req_data     [N_REQ];
  logic [N_REQ-1:0] req_wr_rf;

  modport master (
    output req_valid, req_rob_addr, req_phy_addr, req_data, req_wr_rf,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_rob_addr, req_phy_addr, req_data, req_wr_rf,
    output req_ready
  );

endinterface

// File: rtl/cdb_arbiter_rr.sv
// Combinational round-robin arbiter.
// Scans req starting at index ptr and wrapping modulo N. The first set bit
// wins. Nothing is granted while en is low.
// Ports:
//   req   : request vector
//   ptr   : highest-priority index for this cycle (must be < N)
//   en    : grant enable
//   grant : one-hot grant (all zero when nothing wins)
//   idx   : binary index of the granted requester (0 when none)
module rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  input  logic            en,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] idx
);

  logic [ID_W-1:0] cand;
  logic            hit;

  always_comb begin
    grant = '0;
    idx   = '0;
    cand  = '0;
    hit   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = ID_W'((32'(ptr) + i) % N);
      if (en && !hit && req[cand]) begin
        grant[cand] = 1'b1;
        idx         = cand;
        hit         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter.
// Shares the single writeback/retire broadcast among N_REQ functional-unit
// result ports using round-robin arbitration. Each accepted result produces
// one registered broadcast, one cycle later, to the ROB, the physical
// register file and the busy table.
// Ports:
//   clk, rst  : clock, asynchronous active-low reset
//   flush     : squash; suppresses grants this cycle
//   req_bus   : result requests (valid/ready plus payload)
//   retire_*  : ROB completion broadcast
//   phy_rf_*  : register-file write port
//   busy_table_* : busy-bit clear
//   grant_id  : index granted last cycle, qualified by retire_en
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  cdb_arbiter_if.slave        req_bus,
  output logic                retire_en,
  output rob_addr_t           retire_rob_addr,
  output phy_rf_data_t        retire_value,
  output logic                phy_rf_wr_en,
  output phy_rf_addr_t        phy_rf_wr_addr,
  output phy_rf_data_t        phy_rf_wr_data,
  output logic                busy_table_wr_en,
  output phy_rf_addr_t        busy_table_wr_addr,
  output logic                busy_table_wr_data,
  output logic [ID_W-1:0]     grant_id
);

  logic [ID_W-1:0]  ptr;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  gidx;
  logic             granted;
  logic             arb_en;
  cdb_pkt_t         pkt [N_REQ];

  cdb_pkt_t         out_pkt;
  logic             out_en;
  logic [ID_W-1:0]  out_id;

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      pkt[i].rob_addr = req_bus.req_rob_addr[i];
      pkt[i].phy_addr = req_bus.req_phy_addr[i];
      pkt[i].data     = req_bus.req_data[i];
      pkt[i].wr_rf    = req_bus.req_wr_rf[i];
    end
  end

  // rst is also used combinationally so no ready is shown while in reset.
  assign arb_en = rst & ~flush;

  rr_arbiter #(
    .N    (N_REQ),
    .ID_W (ID_W)
  ) u_rr (
    .req   (req_bus.req_valid),
    .ptr   (ptr),
    .en    (arb_en),
    .grant (grant),
    .idx   (gidx)
  );

  assign granted           = |grant;
  assign req_bus.req_ready = grant;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (granted) begin
      ptr <= (gidx == ID_W'(N_REQ - 1)) ? '0 : gidx + 1'b1;
    end
  end

  // Payload and id hold when idle; only the enable is cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_en  <= 1'b0;
      out_pkt <= '0;
      out_id  <= '0;
    end else begin
      out_en <= granted;
      if (granted) begin
        out_pkt <= pkt[gidx];
        out_id  <= gidx;
      end
    end
  end

  assign retire_en          = out_en;
  assign retire_rob_addr    = out_pkt.rob_addr;
  assign retire_value       = out_pkt.data;
  assign phy_rf_wr_en       = out_en & out_pkt.wr_rf;
  assign phy_rf_wr_addr     = out_pkt.phy_addr;
  assign phy_rf_wr_data     = out_pkt.data;
  assign busy_table_wr_en   = out_en & out_pkt.wr_rf;
  assign busy_table_wr_addr = out_pkt.phy_addr;
  assign busy_table_wr_data = 1'b0;
  assign grant_id           = out_id;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned ID_W  = 2;

  logic            clk;
  logic            rst;
  logic            flush;
  logic            retire_en;
  rob_addr_t       retire_rob_addr;
  phy_rf_data_t    retire_value;
  logic            phy_rf_wr_en;
  phy_rf_addr_t    phy_rf_wr_addr;
  phy_rf_data_t    phy_rf_wr_data;
  logic            busy_table_wr_en;
  phy_rf_addr_t    busy_table_wr_addr;
  logic            busy_table_wr_data;
  logic [ID_W-1:0] grant_id;

  int n_cmp;
  int n_err;

  cdb_arbiter_if #(.N_REQ(N_REQ)) bus ();

  cdb_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .flush              (flush),
    .req_bus            (bus),
    .retire_en          (retire_en),
    .retire_rob_addr    (retire_rob_addr),
    .retire_value       (retire_value),
    .phy_rf_wr_en       (phy_rf_wr_en),
    .phy_rf_wr_addr     (phy_rf_wr_addr),
    .phy_rf_wr_data     (phy_rf_wr_data),
    .busy_table_wr_en   (busy_table_wr_en),
    .busy_table_wr_addr (busy_table_wr_addr),
    .busy_table_wr_data (busy_table_wr_data),
    .grant_id           (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_pkt(input int unsigned i, input logic [4:0] rob, input logic [5:0] phy,
                         input logic [31:0] data, input logic wr);
    bus.req_rob_addr[i] = rob;
    bus.req_phy_addr[i] = phy;
    bus.req_data[i]     = data;
    bus.req_wr_rf[i]    = wr;
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_ready"},    64'(bus.req_ready), 64'd0);
    check({pfx, "_ret_en"},   64'(retire_en), 64'd0);
    check({pfx, "_ret_rob"},  64'(retire_rob_addr), 64'd0);
    check({pfx, "_ret_val"},  64'(retire_value), 64'd0);
    check({pfx, "_rf_en"},    64'(phy_rf_wr_en), 64'd0);
    check({pfx, "_rf_addr"},  64'(phy_rf_wr_addr), 64'd0);
    check({pfx, "_rf_data"},  64'(phy_rf_wr_data), 64'd0);
    check({pfx, "_bt_en"},    64'(busy_table_wr_en), 64'd0);
    check({pfx, "_bt_addr"},  64'(busy_table_wr_addr), 64'd0);
    check({pfx, "_bt_data"},  64'(busy_table_wr_data), 64'd0);
    check({pfx, "_gid"},      64'(grant_id), 64'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b0;
    flush = 1'b0;
    bus.req_valid = '0;
    for (int unsigned i = 0; i < N_REQ; i++) set_pkt(i, 5'd0, 6'd0, 32'd0, 1'b0);

    // Reset state; valid requests must not be granted while in reset.
    tick;
    tick;
    bus.req_valid = 4'b1111;
    #1;
    check_all_zero("reset");
    bus.req_valid = '0;
    rst = 1'b1;
    tick;

    // Single request from unit 2 (ptr 0 -> searches 0,1,2).
    set_pkt(2, 5'd1, 6'd5, 32'd33, 1'b1);
    bus.req_valid = 4'b0100;
    #1;
    check("single_ready", 64'(bus.req_ready), 64'b0100);
    tick;
    bus.req_valid = '0;
    check("single_ret_en",  64'(retire_en), 64'd1);
    check("single_ret_rob", 64'(retire_rob_addr), 64'd1);
    check("single_ret_val", 64'(retire_value), 64'd33);
    check("single_rf_en",   64'(phy_rf_wr_en), 64'd1);
    check("single_rf_addr", 64'(phy_rf_wr_addr), 64'd5);
    check("single_rf_data", 64'(phy_rf_wr_data), 64'd33);
    check("single_bt_en",   64'(busy_table_wr_en), 64'd1);
    check("single_bt_addr", 64'(busy_table_wr_addr), 64'd5);
    check("single_bt_data", 64'(busy_table_wr_data), 64'd0);
    check("single_gid",     64'(grant_id), 64'd2);
    tick;
    check("idle_ret_en", 64'(retire_en), 64'd0);
    check("idle_rf_en",  64'(phy_rf_wr_en), 64'd0);
    check("idle_bt_en",  64'(busy_table_wr_en), 64'd0);

    // Store from unit 0 with ptr 3: search wraps 3 -> 0.
    set_pkt(0, 5'd7, 6'd9, 32'h55, 1'b0);
    bus.req_valid = 4'b0001;
    #1;
    check("store_ready", 64'(bus.req_ready), 64'b0001);
    tick;
    bus.req_valid = '0;
    check("store_ret_en",  64'(retire_en), 64'd1);
    check("store_ret_rob", 64'(retire_rob_addr), 64'd7);
    check("store_rf_en",   64'(phy_rf_wr_en), 64'd0);
    check("store_bt_en",   64'(busy_table_wr_en), 64'd0);
    check("store_gid",     64'(grant_id), 64'd0);

    // Grant unit 1 so ptr becomes 2, then units 1 and 3 compete.
    set_pkt(1, 5'd11, 6'd21, 32'h111, 1'b1);
    set_pkt(3, 5'd13, 6'd23, 32'h333, 1'b1);
    bus.req_valid = 4'b0010;
    tick;
    bus.req_valid = 4'b1010;
    #1;
    check("rr13_first_ready", 64'(bus.req_ready), 64'b1000);
    tick;
    bus.req_valid = 4'b0010;
    check("rr13_first_gid", 64'(grant_id), 64'd3);
    check("rr13_first_val", 64'(retire_value), 64'h333);
    #1;
    check("rr13_second_ready", 64'(bus.req_ready), 64'b0010);
    tick;
    bus.req_valid = 4'b1111;
    check("rr13_second_gid", 64'(grant_id), 64'd1);
    #1;
    check("rr13_ptr_at_2", 64'(bus.req_ready), 64'b0100);

    // Flush blocks the grant for one cycle; ptr stays at 2.
    bus.req_valid = 4'b0011;
    flush = 1'b1;
    #1;
    check("flush_ready", 64'(bus.req_ready), 64'd0);
    tick;
    check("flush_no_bcast", 64'(retire_en), 64'd0);
    flush = 1'b0;
    #1;
    check("post_flush_ready", 64'(bus.req_ready), 64'b0001);
    tick;
    bus.req_valid = 4'b0010;
    check("post_flush_gid0", 64'(grant_id), 64'd0);
    check("post_flush_en0",  64'(retire_en), 64'd1);
    tick;
    check("post_flush_gid1", 64'(grant_id), 64'd1);

    // ptr = 2: grant unit 2, then reset while that broadcast is pending.
    bus.req_valid = 4'b1111;
    tick;
    check("pre_rst_en",  64'(retire_en), 64'd1);
    check("pre_rst_gid", 64'(grant_id), 64'd2);
    rst = 1'b0;
    #1;
    check_all_zero("async_rst");
    bus.req_valid = 4'b0110;
    tick;
    tick;
    rst = 1'b1;
    #1;
    check("rst_release_ready", 64'(bus.req_ready), 64'b0010);
    tick;
    bus.req_valid = '0;
    check("rst_release_gid", 64'(grant_id), 64'd1);
    check("rst_release_val", 64'(retire_value), 64'h111);

    // All four valid continuously from reset: 0,1,2,3,0 back to back.
    for (int unsigned i = 0; i < N_REQ; i++)
      set_pkt(i, 5'(i), 6'(10 + i), 32'(100 + i), 1'b1);
    rst = 1'b0;
    tick;
    bus.req_valid = 4'b1111;
    rst = 1'b1;
    for (int unsigned k = 0; k < 5; k++) begin
      tick;
      check($sformatf("all4_en_%0d", k),  64'(retire_en), 64'd1);
      check($sformatf("all4_gid_%0d", k), 64'(grant_id), 64'(k % 4));
      check($sformatf("all4_val_%0d", k), 64'(retire_value), 64'(100 + (k % 4)));
    end
    bus.req_valid = '0;
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
